bcd_conv_sched: RTL and testbench
=================================

BCD_CONV_SCHED -- requirements
Module: bcd_conv_sched

Interface
REQ-001 SHALL have parameter NCH, default 4, number of requesting channels.
REQ-002 SHALL have parameter WIDTH, default 16, binary operand width.
REQ-003 SHALL have parameter TIMEOUT, default 64, maximum WAIT cycles before abort.
REQ-004 SHALL use one clock and a synchronous, active-high reset.
REQ-005 clk  in  1  sole clock; all state changes on the rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 req  in  NCH  per-channel level request; held until ack.
REQ-008 bin_flat  in  NCH*WIDTH  channel k operand at bits [k*WIDTH +: WIDTH].
REQ-009 ack  out  NCH  one-cycle completion pulse to the served channel.
REQ-010 err  out  1  one-cycle pulse; served conversion timed out.
REQ-011 out_valid  out  1  one-cycle pulse; out_ch and out_bcd are valid.
REQ-012 out_ch  out  clog2(NCH)  channel index of the published result.
REQ-013 out_bcd  out  20  packed digits {bcd4,bcd3,bcd2,bcd1,bcd0}.
REQ-014 cv_start  out  1  start pulse to the shared bin2bcd converter.
REQ-015 cv_bin  out  WIDTH  operand driven to the converter.
REQ-016 cv_ready / cv_done_tick  in  1 each  converter idle flag and completion tick.
REQ-017 cv_bcd  in  20  converter digits, packed as out_bcd.

Function
REQ-018 SHALL share one bin2bcd converter among NCH requesters; at most one conversion is in flight.
REQ-019 SHALL implement FSM states IDLE, ISSUE, WAIT, PUBLISH.
REQ-020 IDLE: when cv_ready=1 and req!=0, SHALL pick a channel round-robin starting at last_grant+1, latch its operand and index, then go to ISSUE; otherwise stay in IDLE.
REQ-021 req SHALL be sampled only in IDLE; a req dropped before grant is simply not served.
REQ-022 ISSUE: SHALL drive cv_start=1 for exactly one cycle with cv_bin equal to the latched operand, clear the watchdog, then go to WAIT.
REQ-023 cv_bin SHALL hold the latched operand from ISSUE until leaving WAIT.
REQ-024 WAIT: on cv_done_tick=1, SHALL register cv_bcd and go to PUBLISH.
REQ-025 WAIT: if the watchdog reaches TIMEOUT-1 without cv_done_tick, SHALL pulse err and ack[ch] in the next cycle, leave out_valid=0, and return to IDLE.
REQ-026 If cv_done_tick and the timeout coincide, completion SHALL win.
REQ-027 PUBLISH: SHALL pulse out_valid and ack[ch] for one cycle, set last_grant=ch, then go to IDLE.
REQ-028 out_valid SHALL rise in the cycle after cv_done_tick; the IDLE-to-cv_start latency is 1 cycle.
REQ-029 A req dropped after grant SHALL NOT abort service; ack still pulses.
REQ-030 The requester SHALL clear req on the edge that samples ack=1; with req held high, other pending channels SHALL be served before the same channel again.
REQ-031 cv_done_tick outside WAIT SHALL be ignored.

Reset
REQ-032 rst SHALL force state=IDLE and last_grant=NCH-1, so channel 0 has first priority.
REQ-033 rst SHALL clear ack, err, out_valid, out_ch, out_bcd, cv_start, cv_bin, and the watchdog to 0.
REQ-034 A reset mid-operation (ISSUE/WAIT/PUBLISH) SHALL abandon the conversion with no ack, err, or out_valid.

Structure
REQ-035 Package bcd_sched_pkg SHALL hold the state encoding, NCH/WIDTH/TIMEOUT defaults, and DIGITS=5.
REQ-036 Round-robin selection SHALL be a sub-module rr_arbiter: inputs req and last_grant, outputs a one-hot grant and its index.
REQ-037 The converter SHALL be instantiated outside this block.

Verification
REQ-038 After reset, req=0001, ch0 operand=12345 -> one cv_start; out_valid with out_ch=0, out_bcd digits 1,2,3,4,5; ack=0001.
REQ-039 req=1111 asserted simultaneously after reset -> acks in order ch0, ch1, ch2, ch3; exactly 4 cv_start pulses.
REQ-040 Operands 0 and 65535 -> out_bcd 0,0,0,0,0 and 6,5,5,3,5.
REQ-041 ch0 req held high, ch2 raised during ch0 WAIT -> next grant is ch2, then ch0.
REQ-042 Converter model never asserts cv_done_tick -> err and ack pulse 64 cycles after cv_start; out_valid stays 0; FSM returns to IDLE.
REQ-043 rst asserted in WAIT -> next cycle all outputs 0, state IDLE; a late cv_done_tick produces no out_valid.

Source files
------------

// File: rtl/bcd_sched_pkg.sv
// Shared types and defaults for the bin2bcd converter scheduler.
// Holds the FSM state encoding and the default channel, operand and timeout sizes.
package bcd_sched_pkg;

  localparam int unsigned NCH_DEF     = 4;
  localparam int unsigned WIDTH_DEF   = 16;
  localparam int unsigned TIMEOUT_DEF = 64;
  localparam int unsigned DIGITS      = 5;
  localparam int unsigned BCD_W       = 4 * DIGITS;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT    = 2'd2,
    ST_PUBLISH = 2'd3
  } state_e;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: first requester strictly after last_grant_i, wrapping around.
// Outputs a one-hot grant and its index; all-zero when nothing requests.
module rr_arbiter
  import bcd_sched_pkg::*;
#(
  parameter  int unsigned NCH = NCH_DEF,
  localparam int unsigned CW  = idx_w(NCH)
) (
  input  logic [NCH-1:0] req_i,
  input  logic [CW-1:0]  last_grant_i,
  output logic [NCH-1:0] grant_o,
  output logic [CW-1:0]  grant_idx_o
);

  int unsigned   cand;
  logic [CW-1:0] cidx;

  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    cand        = 0;
    cidx        = '0;
    // Offsets are walked from NCH down to 1, so the nearest requester is the last to overwrite.
    for (int unsigned i = 0; i < NCH; i++) begin
      cand = 32'(last_grant_i) + NCH - i;
      if (cand >= NCH) begin
        cand = cand - NCH;
      end
      cidx = CW'(cand);
      if (req_i[cidx]) begin
        grant_o       = '0;
        grant_o[cidx] = 1'b1;
        grant_idx_o   = cidx;
      end
    end
  end

endmodule

// File: rtl/bcd_conv_sched.sv
// Shares one external bin2bcd converter among NCH requesters with round-robin grant,
// a completion watchdog, and registered publish/ack/err pulses.
module bcd_conv_sched
  import bcd_sched_pkg::*;
#(
  parameter  int unsigned NCH     = NCH_DEF,
  parameter  int unsigned WIDTH   = WIDTH_DEF,
  parameter  int unsigned TIMEOUT = TIMEOUT_DEF,
  localparam int unsigned CW      = idx_w(NCH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCH-1:0]       req,
  input  logic [NCH*WIDTH-1:0] bin_flat,
  output logic [NCH-1:0]       ack,
  output logic                 err,
  output logic                 out_valid,
  output logic [CW-1:0]        out_ch,
  output logic [BCD_W-1:0]     out_bcd,
  output logic                 cv_start,
  output logic [WIDTH-1:0]     cv_bin,
  input  logic                 cv_ready,
  input  logic                 cv_done_tick,
  input  logic [BCD_W-1:0]     cv_bcd
);

  localparam int unsigned     WDW     = idx_w(TIMEOUT);
  localparam logic [WDW-1:0]  WD_LAST = WDW'(TIMEOUT - 1);

  state_e           state_q;
  logic [CW-1:0]    last_q;
  logic [CW-1:0]    ch_q;
  logic [NCH-1:0]   gnt_q;
  logic [NCH-1:0]   ack_q;
  logic             err_q;
  logic             ov_q;
  logic [CW-1:0]    out_ch_q;
  logic [BCD_W-1:0] bcd_q;
  logic             start_q;
  logic [WIDTH-1:0] bin_q;
  logic [WDW-1:0]   wd_q;

  logic [NCH-1:0]   arb_req_d;
  logic [NCH-1:0]   grant_d;
  logic [CW-1:0]    grant_idx_d;
  logic [WIDTH-1:0] grant_op_d;

  // A channel whose ack is on the wire this cycle still shows req=1 at the closing edge.
  assign arb_req_d = req & ~ack_q;

  rr_arbiter #(
    .NCH (NCH)
  ) u_arb (
    .req_i        (arb_req_d),
    .last_grant_i (last_q),
    .grant_o      (grant_d),
    .grant_idx_o  (grant_idx_d)
  );

  always_comb begin
    grant_op_d = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      if (grant_d[k]) begin
        grant_op_d = bin_flat[k*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      last_q   <= CW'(NCH - 1);
      ch_q     <= '0;
      gnt_q    <= '0;
      ack_q    <= '0;
      err_q    <= 1'b0;
      ov_q     <= 1'b0;
      out_ch_q <= '0;
      bcd_q    <= '0;
      start_q  <= 1'b0;
      bin_q    <= '0;
      wd_q     <= '0;
    end else begin
      ack_q   <= '0;
      err_q   <= 1'b0;
      ov_q    <= 1'b0;
      start_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (cv_ready && (arb_req_d != '0)) begin
            gnt_q   <= grant_d;
            ch_q    <= grant_idx_d;
            bin_q   <= grant_op_d;
            start_q <= 1'b1;
            wd_q    <= '0;
            state_q <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          // The start cycle counts toward the watchdog, so err lands TIMEOUT cycles after cv_start.
          wd_q    <= wd_q + WDW'(1);
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          if (cv_done_tick) begin
            bcd_q    <= cv_bcd;
            out_ch_q <= ch_q;
            ov_q     <= 1'b1;
            ack_q    <= gnt_q;
            state_q  <= ST_PUBLISH;
          end else if (wd_q == WD_LAST) begin
            err_q   <= 1'b1;
            ack_q   <= gnt_q;
            state_q <= ST_IDLE;
          end else begin
            wd_q <= wd_q + WDW'(1);
          end
        end
        ST_PUBLISH: begin
          last_q  <= ch_q;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign ack       = ack_q;
  assign err       = err_q;
  assign out_valid = ov_q;
  assign out_ch    = out_ch_q;
  assign out_bcd   = bcd_q;
  assign cv_start  = start_q;
  assign cv_bin    = bin_q;

endmodule

// File: tb/tb_bcd_conv_sched.sv
// Bench for bcd_conv_sched: behavioural converter and requesters, round-robin and BCD
// reference computed arithmetically, directed scenarios followed by randomized rounds.
module tb_bcd_conv_sched;

  localparam int NCH     = 4;
  localparam int WIDTH   = 16;
  localparam int TIMEOUT = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst;
  logic [NCH-1:0]       req;
  logic [NCH*WIDTH-1:0] bin_flat;
  logic [NCH-1:0]       ack;
  logic                 err;
  logic                 out_valid;
  logic [1:0]           out_ch;
  logic [19:0]          out_bcd;
  logic                 cv_start;
  logic [WIDTH-1:0]     cv_bin;
  logic                 cv_ready;
  logic                 cv_done_tick;
  logic [19:0]          cv_bcd;

  bcd_conv_sched #(.NCH(NCH), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .bin_flat     (bin_flat),
    .ack          (ack),
    .err          (err),
    .out_valid    (out_valid),
    .out_ch       (out_ch),
    .out_bcd      (out_bcd),
    .cv_start     (cv_start),
    .cv_bin       (cv_bin),
    .cv_ready     (cv_ready),
    .cv_done_tick (cv_done_tick),
    .cv_bcd       (cv_bcd)
  );

  int          vectors = 0;
  int          miscompares = 0;
  int unsigned op [NCH];
  logic [NCH-1:0] held, ack_prev;
  int          served_q[$];
  logic [19:0] bcd_hist[$];
  int          n_start = 0, n_valid = 0, n_err = 0;
  bit          in_flight = 0;
  int          exp_ch = 0, last_ref = NCH - 1;
  longint      cyc = 0, start_cyc = 0, done_cyc = -100;
  logic [19:0] last_bcd = '0;
  bit          cbusy = 0, stray = 0;
  int          cage = 0, clat = 5;
  logic [WIDTH-1:0] cbin = '0;

  function automatic logic [19:0] to_bcd(int unsigned v);
    logic [19:0] r;
    r = '0;
    for (int d = 0; d < 5; d++) begin
      r[d*4 +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic int rr_pick(logic [NCH-1:0] pend, int last);
    int c;
    for (int off = 1; off <= NCH; off++) begin
      c = (last + off) % NCH;
      if (pend[c]) return c;
    end
    return -1;
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_op(int k, int unsigned v);
    op[k] = v;
    bin_flat[k*WIDTH +: WIDTH] = WIDTH'(v);
  endtask

  task automatic tick();
    logic [NCH-1:0] pend_pre;
    logic rst_pre;
    pend_pre = req & ~ack;
    rst_pre  = rst;
    @(posedge clk); #1;
    cyc++;
    if (rst_pre) begin
      chk("rst_ack", ack, 0);
      chk("rst_err", err, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_ch", out_ch, 0);
      chk("rst_out_bcd", out_bcd, 0);
      chk("rst_cv_start", cv_start, 0);
      chk("rst_cv_bin", cv_bin, 0);
      in_flight = 0;
      last_ref  = NCH - 1;
    end else begin
      if (cv_start) begin
        n_start++;
        chk("start_while_busy", in_flight, 0);
        exp_ch = rr_pick(pend_pre, last_ref);
        chk("start_has_req", exp_ch >= 0, 1);
        if (exp_ch < 0) exp_ch = 0;
        chk("cv_bin", cv_bin, op[exp_ch]);
        in_flight = 1;
        start_cyc = cyc;
      end else if (in_flight && !out_valid && !err) begin
        chk("cv_bin_hold", cv_bin, op[exp_ch]);
      end
      if (out_valid) begin
        n_valid++;
        chk("valid_in_flight", in_flight, 1);
        chk("out_ch", out_ch, exp_ch);
        chk("out_bcd", out_bcd, to_bcd(op[exp_ch]));
        chk("ack_on_valid", ack, 1 << exp_ch);
        chk("err_on_valid", err, 0);
        chk("valid_latency", cyc - done_cyc, 1);
        served_q.push_back(exp_ch);
        bcd_hist.push_back(out_bcd);
        last_ref  = exp_ch;
        last_bcd  = out_bcd;
        in_flight = 0;
      end else if (err) begin
        n_err++;
        chk("err_in_flight", in_flight, 1);
        chk("ack_on_err", ack, 1 << exp_ch);
        chk("err_delay", cyc - start_cyc, TIMEOUT);
        served_q.push_back(100 + exp_ch);
        in_flight = 0;
      end else begin
        chk("ack_quiet", ack, 0);
      end
    end
    // converter model
    if (cv_start && !rst_pre) begin
      cbusy = (clat >= 0);
      cage  = 0;
      cbin  = cv_bin;
    end else if (cbusy) begin
      cage++;
    end
    cv_done_tick = 1'b0;
    cv_bcd       = 20'($urandom);
    if (cbusy && cage == clat) begin
      cv_done_tick = 1'b1;
      cv_bcd       = to_bcd(cbin);
      cbusy        = 0;
      done_cyc     = cyc;
    end
    if (stray) begin
      cv_done_tick = 1'b1;
      stray        = 0;
    end
    cv_ready = !cbusy;
    // requesters drop req on the edge that sampled ack
    req      = req & ~(ack_prev & ~held);
    ack_prev = ack;
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    req  = '0;
    held = '0;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic run_idle(int max);
    int n;
    n = 0;
    while ((((req & ~held) != 0) || in_flight || cbusy) && n < max) begin
      tick();
      n++;
    end
    chk("idle_bound", n < max, 1);
    repeat (3) tick();
  endtask

  initial begin
    int s0, v0, e0, q0, b0, n, k;
    rst = 1'b1; req = '0; bin_flat = '0; held = '0; ack_prev = '0;
    cv_ready = 1'b1; cv_done_tick = 1'b0; cv_bcd = '0;
    for (int i = 0; i < NCH; i++) op[i] = 0;
    repeat (2) tick();
    rst = 1'b0;
    tick();

    // single channel, 12345
    do_reset();
    s0 = n_start; v0 = n_valid;
    set_op(0, 12345);
    req = 4'b0001;
    run_idle(200);
    chk("s1_starts", n_start - s0, 1);
    chk("s1_valids", n_valid - v0, 1);
    chk("s1_ch", served_q[$], 0);
    chk("s1_bcd", last_bcd, 20'h12345);

    // all four at once after reset
    do_reset();
    for (int i = 0; i < NCH; i++) set_op(i, $urandom_range(0, 65535));
    s0 = n_start; q0 = served_q.size();
    req = 4'b1111;
    run_idle(400);
    chk("s2_starts", n_start - s0, 4);
    chk("s2_count", served_q.size() - q0, 4);
    if (served_q.size() >= q0 + 4)
      for (int i = 0; i < 4; i++) chk("s2_order", served_q[q0 + i], i);

    // operand extremes
    do_reset();
    set_op(0, 0);
    set_op(1, 65535);
    b0 = bcd_hist.size();
    req = 4'b0011;
    run_idle(300);
    chk("s3_count", bcd_hist.size() - b0, 2);
    if (bcd_hist.size() >= b0 + 2) begin
      chk("s3_bcd_zero", bcd_hist[b0], 20'h00000);
      chk("s3_bcd_max", bcd_hist[b0 + 1], 20'h65535);
    end

    // ch0 held, ch2 arrives during ch0 conversion
    do_reset();
    clat = 6;
    set_op(0, 4321);
    set_op(2, 9876);
    s0 = n_start; q0 = served_q.size();
    held = 4'b0001;
    req  = 4'b0001;
    n = 0;
    while (n_start == s0 && n < 50) begin tick(); n++; end
    chk("s4_first_start", n_start - s0, 1);
    repeat (2) tick();
    req[2] = 1'b1;
    n = 0;
    while (served_q.size() < q0 + 3 && n < 300) begin tick(); n++; end
    held = '0;
    req  = '0;
    chk("s4_bound", served_q.size() >= q0 + 3, 1);
    run_idle(200);
    if (served_q.size() >= q0 + 3) begin
      chk("s4_order0", served_q[q0], 0);
      chk("s4_order1", served_q[q0 + 1], 2);
      chk("s4_order2", served_q[q0 + 2], 0);
    end

    // converter never completes
    do_reset();
    clat = -1;
    set_op(3, 777);
    s0 = n_start; v0 = n_valid; e0 = n_err;
    req = 4'b1000;
    run_idle(300);
    chk("s5_err", n_err - e0, 1);
    chk("s5_valid", n_valid - v0, 0);
    chk("s5_starts", n_start - s0, 1);

    // completion on the last watchdog cycle wins; one cycle later it does not
    do_reset();
    clat = TIMEOUT - 1;
    set_op(1, 31415);
    v0 = n_valid; e0 = n_err;
    req = 4'b0010;
    run_idle(300);
    chk("s6_late_ok_valid", n_valid - v0, 1);
    chk("s6_late_ok_err", n_err - e0, 0);
    clat = TIMEOUT;
    set_op(2, 27182);
    v0 = n_valid; e0 = n_err; s0 = n_start;
    req = 4'b0100;
    run_idle(300);
    chk("s6_too_late_valid", n_valid - v0, 0);
    chk("s6_too_late_err", n_err - e0, 1);
    chk("s6_too_late_starts", n_start - s0, 1);

    // reset while waiting, converter finishes afterwards
    do_reset();
    clat = 10;
    set_op(1, 5555);
    s0 = n_start;
    req = 4'b0010;
    n = 0;
    while (n_start == s0 && n < 50) begin tick(); n++; end
    chk("s7_started", n_start - s0, 1);
    repeat (3) tick();
    rst = 1'b1;
    req = '0;
    tick();
    rst = 1'b0;
    v0 = n_valid; e0 = n_err; s0 = n_start;
    repeat (20) tick();
    chk("s7_no_valid", n_valid - v0, 0);
    chk("s7_no_err", n_err - e0, 0);
    chk("s7_no_start", n_start - s0, 0);

    // done tick while idle
    v0 = n_valid;
    stray = 1;
    repeat (5) tick();
    chk("s8_stray_ignored", n_valid - v0, 0);

    // randomized rounds
    do_reset();
    for (int r = 0; r < 40; r++) begin
      clat = $urandom_range(1, 12);
      for (int i = 0; i < NCH; i++)
        if (!req[i] && $urandom_range(0, 1) == 1) begin
          set_op(i, $urandom_range(0, 65535));
          req[i] = 1'b1;
        end
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(0, 3)) tick();
        k = $urandom_range(0, NCH - 1);
        req[k] = 1'b0;
      end
      run_idle(1000);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
